alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Pipelined decode stage that turns RV32I integer-computational instruction words into the AluOp control and operand selects consumed by alu.
- Inverse of the ALU encoding: extracts {funct7[5], funct3} into AluOp, and rejects encodings the ALU cannot execute.
- Sits between fetch and execute. Valid/ready handshakes on both sides, one-cycle latency, two-entry skid buffer for full throughput under backpressure.

Parameters:
- RESET_PC_TAG, 32'h0, value driven on out_pc while idle and after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous; discards all held instructions.
- in_valid  input  1  in_instr/in_pc valid.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  Word  raw instruction.
- in_pc  input  Word  instruction address.
- out_valid  output  1  decoded payload valid.
- out_ready  input  1  execute consumes this cycle.
- out_op  output  AluOp  ALU operation.
- out_rs1, out_rs2, out_rd  output  5 each  register indices.
- out_imm  output  Word  decoded immediate.
- out_use_imm  output  Bool  ALU operand b is out_imm, not rs2.
- out_use_pc  output  Bool  ALU operand a is out_pc, not rs1.
- out_pc  output  Word  pc of the decoded instruction.
- out_illegal  output  Bool  instruction is not a supported ALU instruction.

Behaviour:
- Reset (async, active-high):
  - out_valid=0; in_ready=1; skid empty.
  - All payload outputs 0, except out_pc=RESET_PC_TAG and out_op=ADD.
- Decode (combinational on input, registered with the payload):
  - OP (0110011), op={funct7[5],funct3}, use_imm=0. Legal iff funct7==0000000, or funct7==0100000 with funct3 in {000,101}.
  - OP-IMM (0010011), use_imm=1.
    - imm = sign-extended instr[31:20].
    - funct3=001: legal iff instr[31:25]==0; op=SLL; imm={27'b0,instr[24:20]}.
    - funct3=101: instr[31:25]==0000000 gives SRL; 0100000 gives SRA; anything else is illegal. imm={27'b0,instr[24:20]}.
    - Other funct3: op={1'b0,funct3}. There is no SUB-immediate.
  - LUI (0110111): op=ADD, rs1 forced 0, use_imm=1, imm={instr[31:12],12'b0}.
  - AUIPC (0010111): op=ADD, use_pc=1, use_imm=1, imm as for LUI.
  - Anything else, or instr[1:0]!=11: illegal.
  - Illegal instructions still flow through the pipeline, with out_illegal=1, op=ADD, rd=0 and use_imm=0.
  - rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7] unless forced above.
- Handshake:
  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
  - in_ready = !skid_valid, driven straight from a register with no combinational path from out_ready.
  - Accepted instruction appears on out_valid the next cycle (latency 1).
  - Throughput is 1 instruction/cycle while out_ready=1.
  - Output register held (out_valid&&!out_ready) and input accepted: decoded word goes to skid; in_ready=0 next cycle.
  - Output consumed with skid full: skid moves to output, skid empties, in_ready=1 next cycle.
  - Payload must be stable while out_valid&&!out_ready. Order is strictly FIFO.
  - Output register empty, or consumed this cycle: a newly accepted word goes directly to the output register.
- flush:
  - Next cycle out_valid=0, skid empty, in_ready=1.
  - Any input offered in the flush cycle is dropped, even if in_ready=1.
  - flush wins over simultaneous accept/consume.
- Reset mid-transfer: everything held is discarded immediately; no partial payload is visible.

Decomposition:
- AluOp, Word and Bool come from the existing shared packages.
- Add an RvOpcode enum (OP, OP_IMM, LUI, AUIPC) and a DecodedAluInstr packed struct to a shared rv_decode package. The struct holds op, rs1, rs2, rd, imm, use_imm, use_pc, pc and illegal.
- One natural sub-module, rv_alu_decoder: purely combinational, in_instr+in_pc to DecodedAluInstr. The stage module holds the output and skid registers and the handshake.

Test Plan:
- Reset: assert reset with in_valid=1 → out_valid=0, in_ready=1, out_op=ADD, out_pc=RESET_PC_TAG.
- Decode, out_ready=1:
  - sub x3,x1,x2 (0x402081B3) → next cycle op=SUB, rs1=1, rs2=2, rd=3, use_imm=0, illegal=0.
  - srai x5,x6,7 (0x40735293) → op=SRA, imm=7, use_imm=1.
  - addi x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF.
- Upper immediates:
  - lui x4,0x12345 (0x12345237) → op=ADD, rs1=0, imm=0x12345000.
  - auipc with in_pc=0x100 → use_pc=1, out_pc=0x100.
- Illegal:
  - 0x00000000 → illegal=1, rd=0.
  - 0x7E0080B3 (funct7=0111111) → illegal=1.
  - slli with instr[25]=1 → illegal=1.
- Backpressure: stream of 4 instrs A,B,C,D, out_ready=0 for 3 cycles → A held stable; B lands in skid; in_ready=0. out_ready=1 → A,B,C,D delivered in order with no loss or duplicates.
- Flush with skid full and in_valid=1 → next cycle out_valid=0, in_ready=1; flushed and offered instrs never appear on the output.

Source files
------------

// File: rtl/alu_decode_stage_pkg.sv
// Shared types for the RV32I ALU decode stage: machine word, ALU op encoding,
// base opcodes and the decoded payload carried between decode and execute.
package alu_decode_stage_pkg;

  typedef logic [31:0] word_t;
  typedef logic        bool_t;

  // ALU op is {funct7[5], funct3}, so the decoder can lift it straight from the instruction
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } rv_opcode_e;

  typedef struct packed {
    alu_op_e     op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    word_t       imm;
    bool_t       use_imm;
    bool_t       use_pc;
    word_t       pc;
    bool_t       illegal;
  } decoded_alu_instr_t;

endpackage

// File: rtl/alu_decode_stage_decoder.sv
// Combinational RV32I ALU-instruction decoder: instruction word and pc in,
// decoded payload out. Unsupported encodings are flagged and neutralised.
module rv_alu_decoder
  import alu_decode_stage_pkg::*;
(
  input  word_t              instr,
  input  word_t              pc,
  output decoded_alu_instr_t dec
);

  logic [6:0] funct7;
  logic [2:0] funct3;
  word_t      imm_i;
  word_t      imm_u;
  word_t      imm_sh;

  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.op      = ALU_ADD;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.pc      = pc;
    dec.illegal = 1'b0;

    case (instr[6:0])
      OPC_OP: begin
        dec.op = alu_op_e'({funct7[5], funct3});
        if (!((funct7 == 7'b0000000) ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        case (funct3)
          3'b001: begin
            dec.op      = ALU_SLL;
            dec.imm     = imm_sh;
            dec.illegal = (funct7 != 7'b0000000);
          end
          3'b101: begin
            dec.imm = imm_sh;
            if (funct7 == 7'b0000000)      dec.op = ALU_SRL;
            else if (funct7 == 7'b0100000) dec.op = ALU_SRA;
            else                           dec.illegal = 1'b1;
          end
          default: dec.op = alu_op_e'({1'b0, funct3});
        endcase
      end
      OPC_LUI: begin
        dec.rs1     = 5'd0;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
      end
      OPC_AUIPC: begin
        dec.use_pc  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal words still travel down the pipe, but must not write a register
    if (dec.illegal) begin
      dec.op      = ALU_ADD;
      dec.rd      = 5'd0;
      dec.use_imm = 1'b0;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage between fetch and execute: one-cycle latency, valid/ready on
// both sides, with a skid register so in_ready never depends on out_ready.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter word_t RESET_PC_TAG = 32'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  word_t      in_instr,
  input  word_t      in_pc,
  output logic       out_valid,
  input  logic       out_ready,
  output alu_op_e    out_op,
  output logic [4:0] out_rs1,
  output logic [4:0] out_rs2,
  output logic [4:0] out_rd,
  output word_t      out_imm,
  output bool_t      out_use_imm,
  output bool_t      out_use_pc,
  output word_t      out_pc,
  output bool_t      out_illegal
);

  decoded_alu_instr_t dec;
  decoded_alu_instr_t out_q;
  decoded_alu_instr_t skid_q;
  logic               out_valid_q;
  logic               skid_valid_q;
  logic               accept;
  logic               out_free;

  rv_alu_decoder u_decoder (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec)
  );

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid_q || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_q.op     <= ALU_ADD;
      out_q.pc     <= RESET_PC_TAG;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      // The skid entry is older than anything on the input, so it drains first
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_q.op;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_use_imm = out_q.use_imm;
  assign out_use_pc  = out_q.use_pc;
  assign out_pc      = out_valid_q ? out_q.pc : RESET_PC_TAG;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: vector table through a scoreboard,
// plus backpressure, flush and mid-transfer reset sequences.
module tb_alu_decode_stage;
  import alu_decode_stage_pkg::*;

  localparam logic [31:0] TAG = 32'h0000_BEE0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        illegal;
    logic        chk_rs2;
    logic        chk_imm;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [3:0]  out_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_use_imm, out_use_pc, out_illegal;

  int   checks = 0;
  int   errors = 0;
  vec_t vt[15];
  vec_t cur;
  vec_t sb[$];

  alu_decode_stage #(.RESET_PC_TAG(TAG)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_use_imm (out_use_imm),
    .out_use_pc  (out_use_pc),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [3:0] op, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic use_imm,
                              input logic use_pc, input logic illegal,
                              input logic chk_rs2, input logic chk_imm);
    vec_t v;
    v.instr = instr; v.pc = pc; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.imm = imm; v.use_imm = use_imm; v.use_pc = use_pc; v.illegal = illegal;
    v.chk_rs2 = chk_rs2; v.chk_imm = chk_imm;
    return v;
  endfunction

  // Scoreboard: compare on output transfer, push on input transfer
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h with nothing outstanding", out_pc);
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk($sformatf("op[%h]", e.instr), {28'b0, out_op}, {28'b0, e.op});
          chk($sformatf("rd[%h]", e.instr), {27'b0, out_rd}, {27'b0, e.rd});
          chk($sformatf("use_imm[%h]", e.instr), {31'b0, out_use_imm}, {31'b0, e.use_imm});
          chk($sformatf("illegal[%h]", e.instr), {31'b0, out_illegal}, {31'b0, e.illegal});
          chk($sformatf("pc[%h]", e.instr), out_pc, e.pc);
          if (!e.illegal) begin
            chk($sformatf("rs1[%h]", e.instr), {27'b0, out_rs1}, {27'b0, e.rs1});
            chk($sformatf("use_pc[%h]", e.instr), {31'b0, out_use_pc}, {31'b0, e.use_pc});
          end
          if (e.chk_rs2) chk($sformatf("rs2[%h]", e.instr), {27'b0, out_rs2}, {27'b0, e.rs2});
          if (e.chk_imm) chk($sformatf("imm[%h]", e.instr), out_imm, e.imm);
        end
      end
      if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  // Offer v until a cycle with in_ready high; returns 1 time unit after the accepting edge
  task automatic send(input vec_t v);
    int  n;
    logic ok;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = v.pc;
    cur      = v;
    n        = 0;
    ok       = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected 1", n);
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = mk(32'h402081B3, 32'h1000, 4'h8, 5'd1, 5'd2, 5'd3, 32'h0,        0, 0, 0, 1, 0);
    vt[1]  = mk(32'h40735293, 32'h1004, 4'hD, 5'd6, 5'd0, 5'd5, 32'h7,        1, 0, 0, 0, 1);
    vt[2]  = mk(32'hFFF00093, 32'h1008, 4'h0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1, 0, 0, 0, 1);
    vt[3]  = mk(32'h12345237, 32'h100C, 4'h0, 5'd0, 5'd0, 5'd4, 32'h12345000, 1, 0, 0, 0, 1);
    vt[4]  = mk(32'h00001297, 32'h0100, 4'h0, 5'd0, 5'd0, 5'd5, 32'h00001000, 1, 1, 0, 0, 1);
    vt[5]  = mk(32'h00000000, 32'h1010, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        0, 0, 1, 0, 0);
    vt[6]  = mk(32'h7E0080B3, 32'h1014, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        0, 0, 1, 0, 0);
    vt[7]  = mk(32'h02109093, 32'h1018, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        0, 0, 1, 0, 0);
    vt[8]  = mk(32'h00109093, 32'h101C, 4'h1, 5'd1, 5'd0, 5'd1, 32'h1,        1, 0, 0, 0, 1);
    vt[9]  = mk(32'h0F03F393, 32'h1020, 4'h7, 5'd7, 5'd0, 5'd7, 32'hF0,       1, 0, 0, 0, 1);
    vt[10] = mk(32'h4041D133, 32'h1024, 4'hD, 5'd3, 5'd4, 5'd2, 32'h0,        0, 0, 0, 1, 0);
    vt[11] = mk(32'h400010B3, 32'h1028, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        0, 0, 1, 0, 0);
    vt[12] = mk(32'h00000091, 32'h102C, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        0, 0, 1, 0, 0);
    vt[13] = mk(32'h42735293, 32'h1030, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        0, 0, 1, 0, 0);
    vt[14] = mk(32'h00002083, 32'h1034, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        0, 0, 1, 0, 0);

    // Reset with input offered
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = vt[0].instr; in_pc = vt[0].pc; cur = vt[0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_op", {28'b0, out_op}, 32'd0);
    chk("reset_out_pc", out_pc, TAG);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b0;

    // Vector table at full throughput
    for (int i = 0; i < 15; i++) send(vt[i]);
    idle_cycles(4);
    chk("vectors_drained", sb.size(), 0);

    // Backpressure: A held, B in skid, C waits
    out_ready = 1'b0;
    send(vt[9]);
    send(vt[10]);
    in_valid = 1'b1; in_instr = vt[1].instr; in_pc = vt[1].pc; cur = vt[1];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_pc", out_pc, vt[9].pc);
      chk("bp_hold_rd", {27'b0, out_rd}, {27'b0, vt[9].rd});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(vt[1]);
    send(vt[4]);
    idle_cycles(5);
    chk("bp_drained", sb.size(), 0);

    // Flush with skid full and an input offered
    out_ready = 1'b0;
    send(vt[2]);
    send(vt[3]);
    in_valid = 1'b1; in_instr = vt[8].instr; in_pc = vt[8].pc; cur = vt[8];
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_out_pc", out_pc, TAG);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vt[9]);
    idle_cycles(4);
    chk("flush_drained", sb.size(), 0);

    // Reset while an instruction is held on the output
    out_ready = 1'b0;
    send(vt[0]);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_out_pc", out_pc, TAG);
    chk("rst_mid_out_rd", {27'b0, out_rd}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    idle_cycles(4);
    chk("final_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
